alu_bit_sequencer: RTL and testbench
====================================

Name: alu_bit_sequencer

Overview:
- Upstream sequencer for the 1-bit logic unit (AND/XOR/OR/NOT selected by a 2-bit decoded opcode).
- Accepts WIDTH-bit operand words and an opcode over a valid/ready handshake.
- Streams one operand-bit pair per cycle into the logic unit, LSB first, and reassembles the returned result bits into a word.
- Presents the completed word on a valid/ready output handshake.

Parameters:
- WIDTH, 8, operand/result word width in bits (>=2).
- CW, 4, counter width; must satisfy 2^CW > WIDTH.

Ports:
- clk, input, 1, single clock; all state updates on rising edge.
- rst, input, 1, asynchronous active-high reset.
- in_valid, input, 1, request valid.
- in_ready, output, 1, block can accept a request.
- in_op, input, 2, opcode: 00 AND, 01 XOR, 10 OR, 11 NOT (of operand A).
- in_a, input, WIDTH, operand A.
- in_b, input, WIDTH, operand B (ignored by NOT).
- alu_sel_a, output, 1, opcode bit 1 to logic unit decoder.
- alu_sel_b, output, 1, opcode bit 0 to logic unit decoder.
- alu_o0, output, 1, current bit of A to logic unit.
- alu_o1, output, 1, current bit of B to logic unit.
- alu_out, input, 1, combinational result bit from logic unit.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts result.
- out_result, output, WIDTH, assembled result.
- out_zero, output, 1, out_result == 0, qualified by out_valid.
- busy, output, 1, high in SHIFT or DONE.

Behaviour:
- Clock is clk. Reset is rst: asynchronous, active-high.
- Reset state:
  - FSM = IDLE.
  - All registers are 0, including the operand/result shift registers, opcode register and bit counter.
  - Outputs: in_ready=1, out_valid=0, out_result=0, out_zero=0, busy=0, alu_sel_a/alu_sel_b/alu_o0/alu_o1=0.
- Reset asserted mid-operation aborts immediately. Partial results are discarded and never presented.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch in_op, in_a, in_b; clear the result register; clear the counter; go to SHIFT.
  - in_valid=0 keeps the FSM in IDLE.
- SHIFT:
  - in_ready=0.
  - alu_sel_a = op[1] and alu_sel_b = op[0], held stable for all WIDTH cycles.
  - alu_o0 = A_shift[0] and alu_o1 = B_shift[0].
  - Each edge: result <= {alu_out, result[WIDTH-1:1]}; A_shift and B_shift shift right by 1; counter increments.
  - When counter == WIDTH-1 at an edge: go to DONE. The final capture happens on that same edge.
  - Exactly WIDTH SHIFT cycles per operation.
- DONE:
  - out_valid=1; out_result and out_zero are stable.
  - alu_o0/alu_o1/alu_sel_a/alu_sel_b = 0.
  - out_ready=1 at an edge: go to IDLE; out_valid drops the next cycle.
  - out_ready=0: hold indefinitely with no change.
  - in_ready=0, so a new request is not accepted on the same edge as the result is consumed. Minimum issue interval is WIDTH+2 cycles.
- Latency: request accepted at edge k, out_valid=1 starting after edge k+WIDTH.
- In IDLE, alu_o0/alu_o1/alu_sel_a/alu_sel_b = 0. out_result retains the last value; out_valid=0.
- in_valid while busy is ignored; the upstream must hold it until in_ready.
- The logic unit is combinational; no pipeline register exists between alu_o0/alu_o1 and alu_out.
- out_zero is registered with the DONE transition: the zero check is made on the fully assembled result.

Test Plan (WIDTH=8; the bench models the logic unit as AND=o0&o1, XOR=o0^o1, OR=o0|o1, NOT=~o0):
1. Reset: assert rst mid-cycle with no clock edge -> all outputs read their reset values immediately; after release, in_ready=1.
2. OR: in_op=10, in_a=0xA5, in_b=0x0F, accepted at edge k -> alu_o0 sequence 1,0,1,0,0,1,0,1; out_valid at k+8; out_result=0xAF; out_zero=0.
3. XOR then AND, back-to-back with out_ready=1:
   - 0xA5^0x0F -> 0xAA.
   - 0xF0&0x0F -> 0x00 with out_zero=1.
   - Second accept no earlier than 10 cycles after the first.
4. NOT: in_op=11, in_a=0x3C, in_b=0xFF -> out_result=0xC3; alu_sel_a=alu_sel_b=1 held for all 8 SHIFT cycles.
5. Backpressure: out_ready=0 for 5 cycles after out_valid, in_valid=1 with new operands throughout -> result held unchanged, in_ready=0, no new accept; out_ready=1 -> IDLE, then the new request is accepted.
6. Reset mid-SHIFT after 3 bits of an OR (0xFF|0x00) -> out_valid never asserts for it; the next op XOR 0x12^0x34 -> 0x26.

Source files
------------

// File: rtl/alu_bit_sequencer_if.sv
// Purpose : request/result handshake plus the bit-serial link to the 1-bit logic unit.
// Latency : none (signal bundle only).
// Backpressure: valid/ready on both the request and the result sides.
// Ports   : in_valid/in_ready/in_op/in_a/in_b   request side
//           out_valid/out_ready/out_result/out_zero  result side
//           alu_sel_a/alu_sel_b/alu_o0/alu_o1/alu_out  logic-unit link
//           busy  status
// Modports: slave  = the sequencer itself
//           master = its environment (request producer, result consumer, logic unit)
interface alu_bit_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;

  logic             alu_sel_a;
  logic             alu_sel_b;
  logic             alu_o0;
  logic             alu_o1;
  logic             alu_out;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_zero;

  logic             busy;

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready, alu_out,
    output in_ready, alu_sel_a, alu_sel_b, alu_o0, alu_o1,
           out_valid, out_result, out_zero, busy
  );

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready, alu_out,
    input  in_ready, alu_sel_a, alu_sel_b, alu_o0, alu_o1,
           out_valid, out_result, out_zero, busy
  );
endinterface

// File: rtl/alu_bit_sequencer.sv
// Purpose : feeds a combinational 1-bit logic unit one operand-bit pair per cycle
//           (LSB first) and reassembles the returned bits into a WIDTH-bit word.
// Latency : request accepted at edge k -> out_valid from edge k+WIDTH; issue interval >= WIDTH+2.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
// Ports   : clk, rst (async, active-high); bus = alu_bit_sequencer_if.slave
//           (request, result, logic-unit link and busy).
module alu_bit_sequencer #(
  parameter int WIDTH = 8,
  parameter int CW    = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  alu_bit_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state;
  logic [1:0]       op_r;
  logic [WIDTH-1:0] a_shift;
  logic [WIDTH-1:0] b_shift;
  logic [WIDTH-1:0] result;
  logic [CW-1:0]    cnt;

  logic [WIDTH-1:0] out_result_r;
  logic             out_zero_r;
  logic             out_valid_r;
  logic             in_ready_r;
  logic             busy_r;

  // Result word including the bit the logic unit is returning this cycle.
  logic [WIDTH-1:0] next_result;
  assign next_result = {bus.alu_out, result[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_r         <= '0;
      a_shift      <= '0;
      b_shift      <= '0;
      result       <= '0;
      cnt          <= '0;
      out_result_r <= '0;
      out_zero_r   <= 1'b0;
      out_valid_r  <= 1'b0;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            state      <= SHIFT;
            op_r       <= bus.in_op;
            a_shift    <= bus.in_a;
            b_shift    <= bus.in_b;
            result     <= '0;
            cnt        <= '0;
            in_ready_r <= 1'b0;
            busy_r     <= 1'b1;
          end
        end

        SHIFT: begin
          // Zeros shift in from the top, so after WIDTH shifts both operand
          // registers are empty and alu_o0/alu_o1 fall to 0 without extra gating.
          result  <= next_result;
          a_shift <= a_shift >> 1;
          b_shift <= b_shift >> 1;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST_BIT) begin
            // Final capture: publish the fully assembled word and its zero flag.
            state        <= DONE;
            op_r         <= '0;
            out_result_r <= next_result;
            out_zero_r   <= (next_result == '0);
            out_valid_r  <= 1'b1;
          end
        end

        DONE: begin
          // in_ready stays low here, so a new request cannot be taken on the
          // same edge that the result is consumed.
          if (bus.out_ready) begin
            state       <= IDLE;
            out_valid_r <= 1'b0;
            out_zero_r  <= 1'b0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b0;
          end
        end

        default: begin
          state       <= IDLE;
          op_r        <= '0;
          out_valid_r <= 1'b0;
          out_zero_r  <= 1'b0;
          in_ready_r  <= 1'b1;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

  // Every output comes straight from a register.
  assign bus.in_ready   = in_ready_r;
  assign bus.busy       = busy_r;
  assign bus.alu_sel_a  = op_r[1];
  assign bus.alu_sel_b  = op_r[0];
  assign bus.alu_o0     = a_shift[0];
  assign bus.alu_o1     = b_shift[0];
  assign bus.out_valid  = out_valid_r;
  assign bus.out_result = out_result_r;
  assign bus.out_zero   = out_zero_r;

endmodule

// File: tb/tb_alu_bit_sequencer.sv
// Purpose : self-checking bench for alu_bit_sequencer with a word-level scoreboard.
// Latency : n/a.
// Backpressure: drives out_ready low for a while to exercise result hold.
module tb_alu_bit_sequencer;
  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;

  alu_bit_sequencer_if #(.WIDTH(WIDTH)) bus ();

  alu_bit_sequencer #(.WIDTH(WIDTH), .CW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational 1-bit logic unit.
  always_comb begin
    case ({bus.alu_sel_a, bus.alu_sel_b})
      2'b00:   bus.alu_out = bus.alu_o0 & bus.alu_o1;
      2'b01:   bus.alu_out = bus.alu_o0 ^ bus.alu_o1;
      2'b10:   bus.alu_out = bus.alu_o0 | bus.alu_o1;
      default: bus.alu_out = ~bus.alu_o0;
    endcase
  end

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             zero;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [WIDTH-1:0] model(input logic [1:0] op,
                                              input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a ^ b;
      2'b10:   return a | b;
      default: return ~a;
    endcase
  endfunction

  // Result monitor: compare on each completed output handshake.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      check("unexpected_result", sb.size() != 0, 1);
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", bus.out_result, e.res);
        check("zero", bus.out_zero, e.zero);
      end
    end
  end

  // Presents a request and waits (bounded) for the accepting edge.
  task automatic send(input logic [1:0] op, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, output int acc);
    logic rdy;
    logic done;
    exp_t e;
    done = 1'b0;
    acc  = -1;
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int n = 0; n < 100 && !done; n++) begin
      @(negedge clk);
      rdy = bus.in_ready;
      @(posedge clk);
      #1;
      if (rdy) begin
        done = 1'b1;
        acc  = cyc;
      end
    end
    bus.in_valid = 1'b0;
    check("accept", done, 1);
    if (done) begin
      e.res  = model(op, a, b);
      e.zero = (e.res == '0);
      sb.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int k, k2, rel;
    logic [WIDTH-1:0] a;
    logic seen;

    bus.in_valid  = 1'b0;
    bus.in_op     = 2'b00;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // 1. Reset asserted between edges: outputs take reset values at once.
    #1 rst = 1'b1;
    #1;
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_out_result", bus.out_result, 0);
    check("rst_out_zero", bus.out_zero, 0);
    check("rst_alu", {bus.alu_sel_a, bus.alu_sel_b, bus.alu_o0, bus.alu_o1}, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // 2. OR 0xA5|0x0F: LSB-first operand stream and WIDTH-cycle latency.
    send(2'b10, 8'hA5, 8'h0F, k);
    a = 8'hA5;
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("or_o0_seq", bus.alu_o0, a[i]);
      check("or_busy", bus.busy, 1);
      if (i == WIDTH - 1) check("or_valid_early", bus.out_valid, 0);
    end
    @(posedge clk);
    #1;
    check("or_valid_latency", bus.out_valid, 1);
    check("or_latency_cycles", cyc - k, WIDTH);
    wait_drain();

    // 3. XOR then AND back-to-back with out_ready held high.
    send(2'b01, 8'hA5, 8'h0F, k);
    send(2'b00, 8'hF0, 8'h0F, k2);
    check("issue_gap_min", (k2 - k) >= (WIDTH + 2), 1);
    wait_drain();

    // 4. NOT 0x3C: both select bits held for every SHIFT cycle.
    send(2'b11, 8'h3C, 8'hFF, k);
    for (int i = 0; i < WIDTH; i++) begin
      @(negedge clk);
      check("not_sel", {bus.alu_sel_a, bus.alu_sel_b}, 2'b11);
    end
    @(posedge clk);
    #1;
    check("done_sel_clear", {bus.alu_sel_a, bus.alu_sel_b, bus.alu_o0, bus.alu_o1}, 0);
    wait_drain();

    // 5. Backpressure with a new request pending throughout.
    bus.out_ready = 1'b0;
    send(2'b00, 8'hCC, 8'hAA, k);
    bus.in_valid = 1'b1;
    bus.in_op    = 2'b10;
    bus.in_a     = 8'h11;
    bus.in_b     = 8'h22;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    check("bp_valid_seen", bus.out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      check("bp_hold_result", bus.out_result, 8'h88);
      check("bp_hold_valid", bus.out_valid, 1);
      check("bp_in_ready", bus.in_ready, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    rel = cyc;
    send(2'b10, 8'h11, 8'h22, k2);
    check("bp_accept_after_release", k2 > rel, 1);
    wait_drain();

    // 6. Reset mid-SHIFT aborts the OR; the following XOR is unaffected.
    send(2'b10, 8'hFF, 8'h00, k);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("abort_busy", bus.busy, 0);
    check("abort_in_ready", bus.in_ready, 1);
    check("abort_out_valid", bus.out_valid, 0);
    check("abort_out_result", bus.out_result, 0);
    check("abort_alu", {bus.alu_sel_a, bus.alu_sel_b, bus.alu_o0, bus.alu_o1}, 0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);
    @(posedge clk);
    #1;
    send(2'b01, 8'h12, 8'h34, k);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
